// File: rtl/dmem_if.sv
// Memory-stage to data-memory request/response bundle.
// master drives requests (core side); slave answers (responder side).
interface dmem_if;
    logic        i_req_M;
    logic        i_wr_en_M;
    logic [31:0] i_addr_M;
    logic [31:0] i_wr_data_M;
    logic [1:0]  i_size_M;
    logic        i_unsigned_M;
    logic        o_ready;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic        o_misaligned;
    logic        o_busy;

    modport master (
        output i_req_M,
        output i_wr_en_M,
        output i_addr_M,
        output i_wr_data_M,
        output i_size_M,
        output i_unsigned_M,
        input  o_ready,
        input  o_rd_valid,
        input  o_rd_data,
        input  o_misaligned,
        input  o_busy
    );

    modport slave (
        input  i_req_M,
        input  i_wr_en_M,
        input  i_addr_M,
        input  i_wr_data_M,
        input  i_size_M,
        input  i_unsigned_M,
        output o_ready,
        output o_rd_valid,
        output o_rd_data,
        output o_misaligned,
        output o_busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: word RAM behind a valid/ready
// handshake, WAIT_CYCLES+1 wait cycles then a one-cycle response.
// Ports: clk, rst (async, active-high), bus (dmem_if.slave):
//   i_req_M/i_wr_en_M/i_addr_M/i_wr_data_M/i_size_M/i_unsigned_M in,
//   o_ready/o_rd_valid/o_rd_data/o_misaligned/o_busy out.
// Macro DMEM_SUBWORD_EN enables byte/half accesses; otherwise every
// access is a word access.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic commit;
    logic capture;

    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
`ifdef DMEM_SUBWORD_EN
    logic [1:0]  size_q;
    logic        uns_q;
`endif

    // With WAIT_CYCLES=0 the access commits straight from IDLE, so
    // the live request is used instead of the captured one.
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
`ifdef DMEM_SUBWORD_EN
    logic [1:0]  acc_size;
    logic        acc_uns;
`endif

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   load_val;
    logic [31:0]   wr_word;
    logic          mis;
    logic          we;

    logic [31:0] rd_data_q;
    logic        mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_req_M) begin
                    capture = 1'b1;
                    if (WC == 4'd0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WC;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Counter runs WAIT_CYCLES..0; the access commits on
                // the edge after it has drained.
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DMEM_SUBWORD_EN
            size_q  <= '0;
            uns_q   <= 1'b0;
`endif
        end else if (capture) begin
            wr_q    <= bus.i_wr_en_M;
            addr_q  <= bus.i_addr_M;
            wdata_q <= bus.i_wr_data_M;
`ifdef DMEM_SUBWORD_EN
            size_q  <= bus.i_size_M;
            uns_q   <= bus.i_unsigned_M;
`endif
        end
    end

    always_comb begin
        acc_wr    = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
`ifdef DMEM_SUBWORD_EN
        acc_size  = size_q;
        acc_uns   = uns_q;
`endif
        if (state_q == IDLE) begin
            acc_wr    = bus.i_wr_en_M;
            acc_addr  = bus.i_addr_M;
            acc_wdata = bus.i_wr_data_M;
`ifdef DMEM_SUBWORD_EN
            acc_size  = bus.i_size_M;
            acc_uns   = bus.i_unsigned_M;
`endif
        end
    end

    // Upper address bits alias; they are deliberately dropped.
    assign idx     = acc_addr[AW+1:2];
    assign lane    = acc_addr[1:0];
    assign rd_word = mem_q[idx];

`ifdef DMEM_SUBWORD_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] st_mask;
    logic [31:0] st_data;

    always_comb begin
        mis      = 1'b0;
        load_val = '0;
        st_mask  = '0;
        st_data  = '0;
        ld_byte  = 8'(rd_word >> {lane, 3'b000});
        ld_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        unique case (acc_size)
            2'b00: begin
                load_val = {{24{~acc_uns & ld_byte[7]}}, ld_byte};
                st_mask  = 32'h0000_00ff << {lane, 3'b000};
                st_data  = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                mis      = lane[0];
                load_val = {{16{~acc_uns & ld_half[15]}}, ld_half};
                st_mask  = lane[1] ? 32'hffff_0000 : 32'h0000_ffff;
                st_data  = {2{acc_wdata[15:0]}};
            end
            2'b10: begin
                mis      = |lane;
                load_val = rd_word;
                st_mask  = 32'hffff_ffff;
                st_data  = acc_wdata;
            end
            default: begin
                mis = 1'b1;
            end
        endcase
        wr_word = (rd_word & ~st_mask) | (st_data & st_mask);
    end
`else
    always_comb begin
        mis      = |lane;
        load_val = rd_word;
        wr_word  = acc_wdata;
    end
`endif

    // A reset landing on the commit edge must not leave a write behind.
    assign we = commit & acc_wr & ~mis & ~rst;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
            mis_q     <= 1'b0;
        end else if (commit) begin
            rd_data_q <= (acc_wr | mis) ? 32'h0 : load_val;
            mis_q     <= mis;
        end
    end

    assign bus.o_ready      = (state_q == IDLE);
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_rd_valid   = (state_q == RESP);
    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_misaligned = mis_q;

    logic unused_bits;
`ifdef DMEM_SUBWORD_EN
    assign unused_bits = ^{acc_addr[31:AW+2]};
`else
    assign unused_bits = ^{acc_addr[31:AW+2], bus.i_size_M,
                           bus.i_unsigned_M};
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
// Sub-word vectors run only when DMEM_SUBWORD_EN is defined.
module tb_dmem_responder;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] r_data;
    logic        r_mis;
    logic [31:0] exp_merge;

    dmem_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction; hold keeps a different request on the bus
    // while busy, which must be ignored.
    task automatic xact(input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz,
                        input logic u, input logic hold);
        int lat;
        int extra;
        @(negedge clk);
        bus.i_req_M      = 1'b1;
        bus.i_wr_en_M    = wr;
        bus.i_addr_M     = a;
        bus.i_wr_data_M  = d;
        bus.i_size_M     = sz;
        bus.i_unsigned_M = u;
        @(posedge clk);
        @(negedge clk);
        chk("ready_wait", 32'(bus.o_ready), 32'd0);
        chk("busy_wait", 32'(bus.o_busy), 32'd1);
        if (hold) begin
            bus.i_addr_M    = a + 32'd4;
            bus.i_wr_data_M = ~d;
        end else begin
            bus.i_req_M = 1'b0;
        end
        lat = 1;
        while (!bus.o_rd_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        bus.i_req_M = 1'b0;
        r_data = bus.o_rd_data;
        r_mis  = bus.o_misaligned;
        chk("latency", 32'(lat), 32'd4);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.o_rd_valid) extra++;
        end
        chk("extra_pulse", 32'(extra), 32'd0);
        chk("hold_data", bus.o_rd_data, r_data);
    endtask

    initial begin
        int pulses;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.i_req_M      = 1'b0;
        bus.i_wr_en_M    = 1'b0;
        bus.i_addr_M     = '0;
        bus.i_wr_data_M  = '0;
        bus.i_size_M     = 2'b10;
        bus.i_unsigned_M = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_valid", 32'(bus.o_rd_valid), 32'd0);
        chk("rst_data", bus.o_rd_data, 32'd0);
        chk("rst_mis", 32'(bus.o_misaligned), 32'd0);
        rst = 1'b0;

        xact(1'b1, 32'h10, 32'hdeadbeef, 2'b10, 1'b0, 1'b0);
        chk("st_data", r_data, 32'h0);
        chk("st_mis", 32'(r_mis), 32'd0);
        xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("ld_word", r_data, 32'hdeadbeef);
        chk("ld_mis", 32'(r_mis), 32'd0);

`ifdef DMEM_SUBWORD_EN
        xact(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1'b0);
        chk("ld_sbyte", r_data, 32'hffffffde);
        xact(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("ld_ubyte", r_data, 32'h000000de);
        xact(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 1'b0);
        chk("ld_shalf", r_data, 32'hffffbeef);
        xact(1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 1'b0);
        chk("ld_half_mis", 32'(r_mis), 32'd1);
        exp_merge = 32'hdead5aef;
`else
        xact(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1'b0);
        chk("ld_byte_as_word", r_data, 32'h0);
        chk("ld_byte_mis", 32'(r_mis), 32'd1);
        exp_merge = 32'hdeadbeef;
`endif
        xact(1'b1, 32'h11, 32'h5a, 2'b00, 1'b0, 1'b0);
        xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("merge", r_data, exp_merge);

        xact(1'b1, 32'h12, 32'h12345678, 2'b10, 1'b0, 1'b0);
        chk("mis_flag", 32'(r_mis), 32'd1);
        chk("mis_data", r_data, 32'h0);
        xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("mis_nowrite", r_data, exp_merge);
        chk("mis_clear", 32'(r_mis), 32'd0);

        xact(1'b1, 32'h400, 32'hcafef00d, 2'b10, 1'b0, 1'b0);
        xact(1'b0, 32'h000, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("wrap", r_data, 32'hcafef00d);

        xact(1'b1, 32'h34, 32'h33333333, 2'b10, 1'b0, 1'b0);
        xact(1'b1, 32'h30, 32'ha5a5a5a5, 2'b10, 1'b0, 1'b1);
        xact(1'b0, 32'h34, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("busy_ignored", r_data, 32'h33333333);
        xact(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("held_store", r_data, 32'ha5a5a5a5);

        xact(1'b1, 32'h20, 32'h77777777, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        bus.i_req_M     = 1'b1;
        bus.i_wr_en_M   = 1'b1;
        bus.i_addr_M    = 32'h20;
        bus.i_wr_data_M = 32'h11111111;
        bus.i_size_M    = 2'b10;
        @(posedge clk);
        @(negedge clk);
        bus.i_req_M = 1'b0;
        chk("pre_rst_busy", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.o_rd_valid) pulses++;
        end
        chk("rst_no_pulse", 32'(pulses), 32'd0);
        xact(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("rst_no_write", r_data, 32'h77777777);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
